// File: rtl/bcd_updown_counter_n_if.sv
// Control/display bus of the N-digit BCD counter. There is no valid/ready handshake:
// every edge with enable=1 (and no load/rst) counts exactly one step, with no backpressure.
interface bcd_updown_counter_n_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic                      up_down;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   load_value;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic                      ovf;
  logic                      at_max;
  logic                      at_zero;

  modport master (
    output enable, up_down, load, load_value,
    input  digits, ovf, at_max, at_zero
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output digits, ovf, at_max, at_zero
  );
endinterface

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with parallel load (nibbles clamped to 9),
// wrap or saturate at the bounds, and a registered overflow pulse.
module bcd_updown_counter_n #(
  parameter int NUM_DIGITS = 4,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_updown_counter_n_if.slave bus
);
  localparam int W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  logic [W-1:0] count;
  logic [W-1:0] next_count;
  logic [W-1:0] load_clamped;
  logic         ovf_q;
  logic         chain;
  logic         chain_out;
  logic [3:0]   digit;
  logic [3:0]   lv;

  // chain is the carry (up) or borrow (down) rippling from digit 0 upward
  always_comb begin
    next_count   = count;
    load_clamped = '0;
    chain        = 1'b1;
    digit        = 4'd0;
    lv           = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (chain) begin
        if (bus.up_down) begin
          if (digit == 4'd9) begin
            next_count[4*i +: 4] = 4'd0;
          end else begin
            next_count[4*i +: 4] = digit + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            next_count[4*i +: 4] = 4'd9;
          end else begin
            next_count[4*i +: 4] = digit - 4'd1;
            chain = 1'b0;
          end
        end
      end
      lv = bus.load_value[4*i +: 4];
      load_clamped[4*i +: 4] = (lv > 4'd9) ? 4'd9 : lv;
    end
    chain_out = chain;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf_q <= 1'b0;
    end else if (bus.load) begin
      count <= load_clamped;
      ovf_q <= 1'b0;
    end else if (bus.enable) begin
      // in saturate mode a count past the bound leaves every digit untouched
      if (!(chain_out && (SATURATE != 0))) begin
        count <= next_count;
      end
      ovf_q <= chain_out;
    end else begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.digits  = count;
  assign bus.ovf     = ovf_q;
  assign bus.at_max  = (count == ALL_NINES);
  assign bus.at_zero = (count == '0);
endmodule
